// File: rtl/pc_sequencer_pkg.sv
//============================================================================
// Module  : pc_sequencer_pkg
// Brief   : Shared types and constants for the program-counter sequencer.
//           The debug unit reuses the state and next-PC select encodings.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package pc_sequencer_pkg;

    // Sequencer run state, also reported to the debug unit
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Next-PC source select
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_SEQ    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_JR     = 3'd4
    } pc_sel_e;

    // Default fetch address after reset
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    // Priority: halt > jump-register > branch > jump > sequential.
    // Without an advance the PC holds regardless of requests.
    function automatic pc_sel_e f_pc_select(
        input logic advance,
        input logic halt,
        input logic jump_reg,
        input logic branch_taken,
        input logic jump
    );
        pc_sel_e sel;
        sel = SEL_HOLD;
        if (advance) begin
            if (halt)              sel = SEL_HOLD;
            else if (jump_reg)     sel = SEL_JR;
            else if (branch_taken) sel = SEL_BRANCH;
            else if (jump)         sel = SEL_JUMP;
            else                   sel = SEL_SEQ;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_jump_target_gen.sv
//============================================================================
// Module  : pc_sequencer_jump_target_gen
// Brief   : J-type target = {pc4 upper bits, instr_index, 2'b00}.
//           Only the upper region bits of pc4 are needed, so only they
//           are passed in.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module pc_sequencer_jump_target_gen #(
    parameter int NBITS     = 32,
    parameter int NBITSJUMP = 26
) (
    input  logic [NBITS-NBITSJUMP-3:0] i_pc4_hi,
    input  logic [NBITSJUMP-1:0]       i_instr_index,
    output logic [NBITS-1:0]           o_target
);

    assign o_target = {i_pc4_hi, i_instr_index, 2'b00};

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//============================================================================
// Module  : pc_sequencer
// Brief   : Program counter owner for the MIPS pipeline. Selects the next
//           fetch address (PC+4, branch, J-type, register jump), applies
//           stall and run/step/halt control and produces the IF flush.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               NBITSJUMP = 26,
    parameter logic [NBITS-1:0] RESET_PC  = NBITS'(c_reset_pc)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_halt,
    input  logic                 i_branch_taken,
    input  logic [NBITS-1:0]     i_branch_target,
    input  logic                 i_jump,
    input  logic [NBITSJUMP-1:0] i_instr_index,
    input  logic                 i_jump_reg,
    input  logic [NBITS-1:0]     i_jr_target,
    output logic [NBITS-1:0]     o_pc,
    output logic [NBITS-1:0]     o_pc4,
    output logic                 o_flush_if,
    output logic                 o_running,
    output logic                 o_halted,
    output logic [31:0]          o_cycle_count
);

    localparam int c_hi_w = NBITS - NBITSJUMP - 2;

    state_e                r_state_q;
    logic                  r_running_q;
    logic                  r_halted_q;
    logic [NBITS-1:0]      r_pc_q;
    logic [NBITS-1:0]      w_pc_d;
    // Only the region bits of the ID-stage pc4 feed the jump target
    logic [c_hi_w-1:0]     r_pc4_id_hi_q;
    logic [31:0]           r_cycle_cnt_q;

    logic                  w_advance;
    pc_sel_e               w_sel;
    logic [NBITS-1:0]      w_pc4;
    logic [NBITS-1:0]      w_jump_target;

    assign w_pc4     = r_pc_q + NBITS'(4);
    assign w_advance = (r_state_q == ST_RUN) && (!i_step_mode || i_step) && !i_stall;
    assign w_sel     = f_pc_select(w_advance, i_halt, i_jump_reg, i_branch_taken, i_jump);

    pc_sequencer_jump_target_gen #(
        .NBITS     (NBITS),
        .NBITSJUMP (NBITSJUMP)
    ) u_jump_target_gen (
        .i_pc4_hi      (r_pc4_id_hi_q),
        .i_instr_index (i_instr_index),
        .o_target      (w_jump_target)
    );

    // Next-PC priority mux
    always_comb begin
        w_pc_d = r_pc_q;
        case (w_sel)
            SEL_SEQ:    w_pc_d = w_pc4;
            SEL_BRANCH: w_pc_d = i_branch_target;
            SEL_JUMP:   w_pc_d = w_jump_target;
            SEL_JR:     w_pc_d = i_jr_target;
            default:    w_pc_d = r_pc_q;
        endcase
    end

    // Run-state machine with registered status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q   <= ST_IDLE;
            r_running_q <= 1'b0;
            r_halted_q  <= 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state_q   <= ST_RUN;
                        r_running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A halt is only accepted together with an advance
                    if (w_advance && i_halt) begin
                        r_state_q   <= ST_HALTED;
                        r_running_q <= 1'b0;
                        r_halted_q  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_state_q <= ST_HALTED;
                end
                default: begin
                    r_state_q   <= ST_IDLE;
                    r_running_q <= 1'b0;
                    r_halted_q  <= 1'b0;
                end
            endcase
        end
    end

    // PC register; only moves in RUN, so IDLE keeps RESET_PC
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc_q <= RESET_PC;
        end else begin
            r_pc_q <= w_pc_d;
        end
    end

    // pc4 of the instruction entering ID, held across stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc4_id_hi_q <= c_hi_w'((RESET_PC + NBITS'(4)) >> (NBITSJUMP + 2));
        end else if (w_advance) begin
            r_pc4_id_hi_q <= w_pc4[NBITS-1:NBITSJUMP+2];
        end
    end

    // Advance-cycle counter, wraps naturally at 2^32
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_cnt_q <= 32'd0;
        end else if (w_advance) begin
            r_cycle_cnt_q <= r_cycle_cnt_q + 32'd1;
        end
    end

    assign o_pc          = r_pc_q;
    assign o_pc4         = w_pc4;
    // Flush the fetched instruction whenever a redirect is accepted
    assign o_flush_if    = (w_sel == SEL_JR) || (w_sel == SEL_BRANCH) || (w_sel == SEL_JUMP);
    assign o_running     = r_running_q;
    assign o_halted      = r_halted_q;
    assign o_cycle_count = r_cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//============================================================================
// Module  : tb_pc_sequencer
// Brief   : Scoreboard bench for pc_sequencer. The stimulus process pushes
//           the expected per-cycle outputs; a monitor pops on every falling
//           edge and compares.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start, step_mode, step, stall, halt;
    logic        branch_taken, jump, jump_reg;
    logic [31:0] branch_target, jr_target;
    logic [25:0] instr_index;
    logic [31:0] pc, pc4, cycle_count;
    logic        flush_if, running, halted;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        flush;
        logic        run;
        logic        halt;
        logic [31:0] cnt;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    pc_sequencer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_step_mode     (step_mode),
        .i_step          (step),
        .i_stall         (stall),
        .i_halt          (halt),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_instr_index   (instr_index),
        .i_jump_reg      (jump_reg),
        .i_jr_target     (jr_target),
        .o_pc            (pc),
        .o_pc4           (pc4),
        .o_flush_if      (flush_if),
        .o_running       (running),
        .o_halted        (halted),
        .o_cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at step %0d: got %h expected %h", nm, tag, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            chk("pc",      m_e.tag, pc,                 m_e.pc);
            chk("pc4",     m_e.tag, pc4,                m_e.pc4);
            chk("flush",   m_e.tag, {31'd0, flush_if},  {31'd0, m_e.flush});
            chk("running", m_e.tag, {31'd0, running},   {31'd0, m_e.run});
            chk("halted",  m_e.tag, {31'd0, halted},    {31'd0, m_e.halt});
            chk("cycles",  m_e.tag, cycle_count,        m_e.cnt);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_out(input logic [31:0] e_pc, input logic e_fl, input logic e_run,
                              input logic e_halt, input logic [31:0] e_cnt);
        exp_t e;
        e.pc    = e_pc;
        e.pc4   = e_pc + 32'd4;
        e.flush = e_fl;
        e.run   = e_run;
        e.halt  = e_halt;
        e.cnt   = e_cnt;
        e.tag   = cyc;
        exp_q.push_back(e);
    endtask

    initial begin
        int adv;
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; stall = 1'b0;
        halt = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        branch_target = 32'h0; jr_target = 32'h0; instr_index = 26'h0;

        // Reset state, then IDLE with start requested
        next_cycle(); expect_out(32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        next_cycle(); rst_n = 1'b1; start = 1'b1;
        expect_out(32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Free running: 0,4,8,C,10
        next_cycle(); start = 1'b0; expect_out(32'h0,  1'b0, 1'b1, 1'b0, 32'd0);
        next_cycle(); expect_out(32'h4,  1'b0, 1'b1, 1'b0, 32'd1);
        next_cycle(); expect_out(32'h8,  1'b0, 1'b1, 1'b0, 32'd2);
        next_cycle(); expect_out(32'hC,  1'b0, 1'b1, 1'b0, 32'd3);
        // Register jump into the 0x4xxx_xxxx region
        next_cycle(); jump_reg = 1'b1; jr_target = 32'h4000_000C;
        expect_out(32'h10, 1'b1, 1'b1, 1'b0, 32'd4);
        next_cycle(); jump_reg = 1'b0;
        expect_out(32'h4000_000C, 1'b0, 1'b1, 1'b0, 32'd5);
        // pc4_id is now 0x4000_0010: J-type jump
        next_cycle(); jump = 1'b1; instr_index = 26'h0000100;
        expect_out(32'h4000_0010, 1'b1, 1'b1, 1'b0, 32'd6);
        // All three redirects together: register jump wins
        next_cycle(); jump = 1'b1; jump_reg = 1'b1; branch_taken = 1'b1;
        jr_target = 32'h80; branch_target = 32'h40;
        expect_out(32'h4000_0400, 1'b1, 1'b1, 1'b0, 32'd7);
        // Stall with branch held: no move, no flush
        next_cycle(); jump = 1'b0; jump_reg = 1'b0; stall = 1'b1; branch_target = 32'h200;
        expect_out(32'h80, 1'b0, 1'b1, 1'b0, 32'd8);
        next_cycle(); expect_out(32'h80, 1'b0, 1'b1, 1'b0, 32'd8);
        next_cycle(); stall = 1'b0; expect_out(32'h80, 1'b1, 1'b1, 1'b0, 32'd8);
        // Jump to top of address space, then sequential wrap to 0
        next_cycle(); branch_taken = 1'b0; jump_reg = 1'b1; jr_target = 32'hFFFF_FFFC;
        expect_out(32'h200, 1'b1, 1'b1, 1'b0, 32'd9);
        next_cycle(); jump_reg = 1'b0;
        expect_out(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'd10);
        next_cycle(); step_mode = 1'b1;
        expect_out(32'h0, 1'b0, 1'b1, 1'b0, 32'd11);
        // Step mode: pulses at i=1,4,7 advance; i=8 pulse under stall is lost
        adv = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            step  = (i == 1 || i == 4 || i == 7 || i == 8);
            stall = (i == 8);
            expect_out(32'(adv * 4), 1'b0, 1'b1, 1'b0, 32'(11 + adv));
            if (i == 1 || i == 4 || i == 7) adv++;
        end
        // Halt with branch while not advancing: ignored
        next_cycle(); step = 1'b0; stall = 1'b0; halt = 1'b1; branch_taken = 1'b1;
        expect_out(32'hC, 1'b0, 1'b1, 1'b0, 32'd14);
        // Step accepts the halt: halt beats branch, no flush
        next_cycle(); step = 1'b1;
        expect_out(32'hC, 1'b0, 1'b1, 1'b0, 32'd14);
        // HALTED: frozen for 5 cycles despite a jump request
        next_cycle(); step = 1'b0; halt = 1'b0; branch_taken = 1'b0; step_mode = 1'b0; jump = 1'b1;
        expect_out(32'hC, 1'b0, 1'b0, 1'b1, 32'd15);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); expect_out(32'hC, 1'b0, 1'b0, 1'b1, 32'd15);
        end
        // Asynchronous reset mid-cycle: outputs return before any edge
        next_cycle(); expect_out(32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        next_cycle(); jump = 1'b0; expect_out(32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
